// File: rtl/spi_slave.sv
// SPI mode 3 responder: oversamples SCLK/CS_N/MOSI on clk and runs full-duplex
// 8-bit MSB-first transfers, with a one-deep TX holding register and an RX strobe.
module spi_slave #(
    parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       tx_underrun,
    output logic       frame_err
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    logic       sclk_meta_r, sclk_s_r, sclk_d_r;
    logic       cs_meta_r, cs_s_r;
    logic       mosi_meta_r, mosi_s_r;
    logic       fall_s, rise_s;

    state_t     state_r, state_n;
    logic [2:0] bit_cnt_r, bit_cnt_n;
    logic [7:0] tx_shift_r, tx_shift_n;
    logic [7:0] rx_shift_r, rx_shift_n;
    logic [7:0] hold_data_r, hold_data_n;
    logic       hold_full_r, hold_full_n;
    logic       miso_r, miso_n;
    logic       oe_r, busy_r, tx_ready_r;
    logic [7:0] rx_data_r, rx_data_n;
    logic       rx_valid_r, rx_valid_n;
    logic       underrun_r, underrun_n;
    logic       frame_err_r, frame_err_n;
    logic       bypass_s;
    logic [7:0] load_byte_s;

    // Two-flop synchronisers plus the SCLK delay stage used for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_meta_r <= 1'b1;
            sclk_s_r    <= 1'b1;
            sclk_d_r    <= 1'b1;
            cs_meta_r   <= 1'b1;
            cs_s_r      <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_s_r    <= 1'b0;
        end else begin
            sclk_meta_r <= spi_sclk;
            sclk_s_r    <= sclk_meta_r;
            sclk_d_r    <= sclk_s_r;
            cs_meta_r   <= spi_cs_n;
            cs_s_r      <= cs_meta_r;
            mosi_meta_r <= spi_mosi;
            mosi_s_r    <= mosi_meta_r;
        end
    end

    assign fall_s = sclk_d_r & ~sclk_s_r;
    assign rise_s = ~sclk_d_r & sclk_s_r;

    // Next-state logic: framing, shifting and the TX holding register
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        tx_shift_n  = tx_shift_r;
        rx_shift_n  = rx_shift_r;
        hold_data_n = hold_data_r;
        hold_full_n = hold_full_r;
        miso_n      = miso_r;
        rx_data_n   = rx_data_r;
        rx_valid_n  = 1'b0;
        underrun_n  = 1'b0;
        frame_err_n = 1'b0;
        bypass_s    = 1'b0;
        load_byte_s = DEFAULT_TX;

        case (state_r)
            IDLE: begin
                if (!cs_s_r) begin
                    state_n   = ACTIVE;
                    bit_cnt_n = 3'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_s_r) begin
                    // Edges in the release cycle are dropped; a partial byte is discarded
                    state_n = IDLE;
                    if (bit_cnt_r != 3'd0) begin
                        frame_err_n = 1'b1;
                        bit_cnt_n   = 3'd0;
                    end else begin
                        frame_err_n = 1'b0;
                    end
                end else begin
                    state_n = ACTIVE;
                    if (fall_s) begin
                        if (bit_cnt_r == 3'd0) begin
                            if (hold_full_r) begin
                                load_byte_s = hold_data_r;
                                hold_full_n = 1'b0;
                            end else if (tx_valid) begin
                                load_byte_s = tx_data;
                                bypass_s    = 1'b1;
                            end else begin
                                load_byte_s = DEFAULT_TX;
                                underrun_n  = 1'b1;
                            end
                            tx_shift_n = load_byte_s;
                            miso_n     = load_byte_s[7];
                        end else begin
                            tx_shift_n = {tx_shift_r[6:0], 1'b0};
                            miso_n     = tx_shift_r[6];
                        end
                    end else if (rise_s) begin
                        rx_shift_n = {rx_shift_r[6:0], mosi_s_r};
                        if (bit_cnt_r == 3'd7) begin
                            rx_data_n  = {rx_shift_r[6:0], mosi_s_r};
                            rx_valid_n = 1'b1;
                            bit_cnt_n  = 3'd0;
                        end else begin
                            bit_cnt_n = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A byte taken by the bypass path must not also land in the hold register
        if (tx_valid && !hold_full_r && !bypass_s) begin
            hold_full_n = 1'b1;
            hold_data_n = tx_data;
        end else begin
            hold_data_n = hold_data_n;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            tx_shift_r  <= 8'h00;
            rx_shift_r  <= 8'h00;
            hold_data_r <= 8'h00;
            hold_full_r <= 1'b0;
            miso_r      <= 1'b1;
            oe_r        <= 1'b0;
            busy_r      <= 1'b0;
            tx_ready_r  <= 1'b1;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            underrun_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            tx_shift_r  <= tx_shift_n;
            rx_shift_r  <= rx_shift_n;
            hold_data_r <= hold_data_n;
            hold_full_r <= hold_full_n;
            miso_r      <= miso_n;
            oe_r        <= (state_n == ACTIVE);
            busy_r      <= (state_n == ACTIVE);
            tx_ready_r  <= ~hold_full_n;
            rx_data_r   <= rx_data_n;
            rx_valid_r  <= rx_valid_n;
            underrun_r  <= underrun_n;
            frame_err_r <= frame_err_n;
        end
    end

    assign spi_miso    = miso_r;
    assign spi_miso_oe = oe_r;
    assign busy        = busy_r;
    assign tx_ready    = tx_ready_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign tx_underrun = underrun_r;
    assign frame_err   = frame_err_r;

endmodule
